// File: rtl/trap_controller_pkg.sv
// trap_controller_pkg: shared FSM state type, mcause codes and mtvec modes
package trap_controller_pkg;
  typedef enum logic [1:0] {IDLE, TAKE, SETTLE} trap_state_t;
  localparam logic [31:0] CAUSE_ILLEGAL_INST = 32'd2;
  localparam logic [31:0] CAUSE_BREAKPOINT = 32'd3;
  localparam logic [31:0] CAUSE_ECALL_M = 32'd11;
  localparam logic [31:0] CAUSE_IRQ_BASE = 32'd16;
  localparam logic [1:0] MTVEC_DIRECT = 2'd0;
  localparam logic [1:0] MTVEC_VECTORED = 2'd1;
endpackage

// File: rtl/trap_controller_irq_sync_edge.sv
// irq_sync_edge: STAGES-deep synchroniser on one async line plus rising-edge pulse
//   CLK, nRST (sync, active-low) | irq: raw line | rise: one-cycle pulse per synchronised rising edge
module irq_sync_edge
  import trap_controller_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic CLK,
  input  logic nRST,
  input  logic irq,
  output logic rise
);
  logic [STAGES-1:0] sync;
  logic prev;
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[STAGES-2:0], irq};
      prev <= sync[STAGES-1];
    end
  end
  assign rise = sync[STAGES-1] & ~prev;
endmodule

// File: rtl/trap_controller.sv
// trap_controller: arbitrates sync exceptions and latched interrupts, sequences trap entry
//   CLK, nRST (sync, active-low); e2m_valid/e2m_pc, illegal_inst/ecall/ebreak: exception sources
//   irq_in[NUM_IRQ]: async lines; mstatus_mie, mie, mtvec_base, mtvec_mode: CSR state
//   trap_valid/is_interrupt/trap_pc/trap_cause/trap_target: one-cycle CSR commit
//   f2d/d2e/e2m/m2w_flush: pipeline flushes; mip_out: pending at [16+:NUM_IRQ]; busy: FSM not IDLE
//   TRAP_VECTORED_EN: when defined, mtvec_mode==1 vectors interrupts to base + 4*cause
module trap_controller
  import trap_controller_pkg::*;
#(
  parameter int NUM_IRQ = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic               e2m_valid,
  input  logic [31:0]        e2m_pc,
  input  logic               illegal_inst,
  input  logic               ecall,
  input  logic               ebreak,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               mstatus_mie,
  input  logic [31:0]        mie,
  input  logic [31:0]        mtvec_base,
  input  logic [1:0]         mtvec_mode,
  output logic               trap_valid,
  output logic               is_interrupt,
  output logic [31:0]        trap_pc,
  output logic [31:0]        trap_cause,
  output logic [31:0]        trap_target,
  output logic               f2d_flush,
  output logic               d2e_flush,
  output logic               e2m_flush,
  output logic               m2w_flush,
  output logic [31:0]        mip_out,
  output logic               busy
);
  trap_state_t state, state_n;
  logic [NUM_IRQ-1:0] rise, pending, cand, clr;
  logic [31:0] pc_q, cause_q, target_q, cause_n, target_n, irq_code;
  logic [4:0] idx, idx_q;
  logic irq_q, any_irq, exc, take;
  logic unused_ok;
  for (genvar g = 0; g < NUM_IRQ; g++) begin : g_sync
    irq_sync_edge #(.STAGES(SYNC_STAGES)) u_sync (.CLK(CLK), .nRST(nRST), .irq(irq_in[g]), .rise(rise[g]));
  end
  assign cand = pending & mie[16 +: NUM_IRQ] & {NUM_IRQ{mstatus_mie}};
  always_comb begin
    idx = '0;
    any_irq = 1'b0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (cand[i]) begin
        idx = 5'(i);
        any_irq = 1'b1;
      end
    end
  end
  assign exc = illegal_inst | ebreak | ecall;
  assign take = (state == IDLE) && e2m_valid && (exc || any_irq);
  assign irq_code = CAUSE_IRQ_BASE + 32'(idx);
  assign cause_n = illegal_inst ? CAUSE_ILLEGAL_INST : ebreak ? CAUSE_BREAKPOINT :
                   ecall ? CAUSE_ECALL_M : (irq_code | 32'h8000_0000);
`ifdef TRAP_VECTORED_EN
  assign target_n = (!exc && mtvec_mode == MTVEC_VECTORED) ? mtvec_base + (irq_code << 2) : mtvec_base;
`else
  assign target_n = mtvec_base;
`endif
  // A rise in the same cycle as the clear keeps the bit set so no edge is lost.
  assign clr = (state == TAKE && irq_q) ? NUM_IRQ'(1) << idx_q : '0;
  assign unused_ok = ^{mie, mtvec_mode};
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state <= IDLE;
      pending <= '0;
      pc_q <= '0;
      cause_q <= '0;
      target_q <= '0;
      irq_q <= 1'b0;
      idx_q <= '0;
    end else begin
      state <= state_n;
      pending <= (pending & ~clr) | rise;
      if (take) begin
        pc_q <= e2m_pc;
        cause_q <= cause_n;
        target_q <= target_n;
        irq_q <= !exc;
        idx_q <= idx;
      end
    end
  end
  always_comb begin
    state_n = state == IDLE ? (take ? TAKE : IDLE) : state == TAKE ? SETTLE : IDLE;
    trap_valid = state == TAKE;
    is_interrupt = trap_valid & irq_q;
    trap_pc = trap_valid ? pc_q : '0;
    trap_cause = trap_valid ? cause_q : '0;
    trap_target = trap_valid ? target_q : '0;
    f2d_flush = trap_valid;
    d2e_flush = trap_valid;
    e2m_flush = trap_valid;
    m2w_flush = trap_valid;
    mip_out = 32'(pending) << 16;
    busy = state != IDLE;
  end
endmodule

// File: tb/tb_trap_controller.sv
// tb_trap_controller: directed checks of trap_controller arbitration, FSM timing and pending handling
module tb_trap_controller;
  logic CLK = 1'b0, nRST = 1'b0;
  logic e2m_valid = 1'b0, illegal_inst = 1'b0, ecall = 1'b0, ebreak = 1'b0, mstatus_mie = 1'b0;
  logic [31:0] e2m_pc = '0, mie = '0, mtvec_base = '0;
  logic [15:0] irq_in = '0;
  logic [1:0] mtvec_mode = '0;
  logic trap_valid, is_interrupt, f2d_flush, d2e_flush, e2m_flush, m2w_flush, busy;
  logic [31:0] trap_pc, trap_cause, trap_target, mip_out;
  int total = 0, passed = 0;
  logic seen;
  trap_controller #(.NUM_IRQ(16), .SYNC_STAGES(2)) dut (
    .CLK(CLK), .nRST(nRST), .e2m_valid(e2m_valid), .e2m_pc(e2m_pc),
    .illegal_inst(illegal_inst), .ecall(ecall), .ebreak(ebreak), .irq_in(irq_in),
    .mstatus_mie(mstatus_mie), .mie(mie), .mtvec_base(mtvec_base), .mtvec_mode(mtvec_mode),
    .trap_valid(trap_valid), .is_interrupt(is_interrupt), .trap_pc(trap_pc),
    .trap_cause(trap_cause), .trap_target(trap_target), .f2d_flush(f2d_flush),
    .d2e_flush(d2e_flush), .e2m_flush(e2m_flush), .m2w_flush(m2w_flush),
    .mip_out(mip_out), .busy(busy)
  );
  always #5 CLK = ~CLK;
  function automatic logic [31:0] tgt(input int i);
`ifdef TRAP_VECTORED_EN
    return 32'h8000 + 32'(4 * (16 + i));
`else
    return 32'h8000 + 32'(0 * i);
`endif
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else passed++;
  endtask
  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    step(2);
    chk("rst_valid", 32'(trap_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_mip", mip_out, 0);
    chk("rst_cause", trap_cause, 0);
    nRST = 1'b1;
    mtvec_base = 32'h8000;
    mtvec_mode = 2'd1;
    e2m_valid = 1'b1;
    e2m_pc = 32'h100;
    illegal_inst = 1'b1;
    step(1);
    e2m_pc = 32'h200;
    illegal_inst = 1'b0;
    chk("ill_valid", 32'(trap_valid), 1);
    chk("ill_cause", trap_cause, 2);
    chk("ill_pc", trap_pc, 32'h100);
    chk("ill_target", trap_target, 32'h8000);
    chk("ill_flush", 32'({f2d_flush, d2e_flush, e2m_flush, m2w_flush}), 32'hF);
    chk("ill_isint", 32'(is_interrupt), 0);
    chk("ill_busy", 32'(busy), 1);
    step(1);
    chk("settle_valid", 32'(trap_valid), 0);
    chk("settle_flush", 32'({f2d_flush, d2e_flush, e2m_flush, m2w_flush}), 0);
    chk("settle_busy", 32'(busy), 1);
    step(1);
    chk("idle_busy", 32'(busy), 0);
    mie = 32'hFFFF_0000;
    mstatus_mie = 1'b1;
    irq_in = 16'h0008;
    step(3);
    chk("irq3_mip", mip_out, 32'h0008_0000);
    chk("irq3_idle", 32'(busy), 0);
    step(1);
    chk("irq3_valid", 32'(trap_valid), 1);
    chk("irq3_cause", trap_cause, 32'h8000_0013);
    chk("irq3_target", trap_target, tgt(3));
    chk("irq3_isint", 32'(is_interrupt), 1);
    step(1);
    chk("irq3_clr", mip_out, 0);
    step(1);
    irq_in = '0;
    step(3);
    irq_in = 16'h0022;
    step(3);
    chk("dual_mip", mip_out, 32'h0022_0000);
    step(1);
    chk("dual1_cause", trap_cause, 32'h8000_0011);
    chk("dual1_target", trap_target, tgt(1));
    step(1);
    chk("dual_mip_left", mip_out, 32'h0020_0000);
    step(1);
    chk("dual_idle", 32'(busy), 0);
    step(1);
    chk("dual5_valid", 32'(trap_valid), 1);
    chk("dual5_cause", trap_cause, 32'h8000_0015);
    chk("dual5_target", trap_target, tgt(5));
    step(2);
    irq_in = '0;
    e2m_valid = 1'b0;
    step(3);
    irq_in = 16'h0001;
    step(4);
    chk("gate_mip", mip_out, 32'h0001_0000);
    chk("gate_busy", 32'(busy), 0);
    e2m_valid = 1'b1;
    illegal_inst = 1'b1;
    step(1);
    illegal_inst = 1'b0;
    chk("prio_cause", trap_cause, 2);
    chk("prio_target", trap_target, 32'h8000);
    step(1);
    chk("prio_mip", mip_out, 32'h0001_0000);
    step(2);
    chk("prio_irq_cause", trap_cause, 32'h8000_0010);
    chk("prio_irq_target", trap_target, tgt(0));
    step(2);
    irq_in = '0;
    mstatus_mie = 1'b0;
    step(3);
    irq_in = 16'h0004;
    step(5);
    chk("mie_off_mip", mip_out, 32'h0004_0000);
    chk("mie_off_valid", 32'(trap_valid), 0);
    chk("mie_off_busy", 32'(busy), 0);
    irq_in = '0;
    step(3);
    irq_in = 16'h0004;
    step(1);
    mstatus_mie = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 2 && !seen; k++) begin
      step(1);
      seen = trap_valid;
    end
    chk("mie_on_trap", 32'(seen), 1);
    chk("mie_on_cause", trap_cause, 32'h8000_0012);
    step(1);
    chk("setwins_mip", mip_out, 32'h0004_0000);
    step(2);
    chk("retake_cause", trap_cause, 32'h8000_0012);
    step(1);
    chk("retake_mip", mip_out, 0);
    step(1);
    irq_in = '0;
    mstatus_mie = 1'b0;
    step(3);
    irq_in = 16'h0010;
    step(3);
    chk("rst_pre_mip", mip_out, 32'h0010_0000);
    ebreak = 1'b1;
    ecall = 1'b1;
    step(1);
    ebreak = 1'b0;
    chk("ebreak_cause", trap_cause, 3);
    step(3);
    chk("ecall_valid", 32'(trap_valid), 1);
    chk("ecall_cause", trap_cause, 11);
    nRST = 1'b0;
    step(1);
    chk("abort_valid", 32'(trap_valid), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_mip", mip_out, 0);
    chk("abort_cause", trap_cause, 0);
    chk("abort_target", trap_target, 0);
    chk("abort_flush", 32'({f2d_flush, d2e_flush, e2m_flush, m2w_flush}), 0);
    ecall = 1'b0;
    nRST = 1'b1;
    step(1);
    chk("post_valid", 32'(trap_valid), 0);
    chk("post_busy", 32'(busy), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/trap_controller.md
# trap_controller

Parametrised successor to the single-source exception unit. Accepts synchronous exceptions from decode (illegal, ecall, ebreak) and up to NUM_IRQ asynchronous interrupt lines, latches interrupts into a pending register, arbitrates by fixed priority, and sequences trap entry through a small FSM. It drives pipeline flushes and hands the CSR file mepc/mcause/target for the commit. It sits between the execute/memory boundary and the CSR block.

## Interface
Parameters:
- NUM_IRQ, 16, number of external interrupt lines (1..16); line i maps to mcause code 16+i
- SYNC_STAGES, 2, flip-flop stages per interrupt synchroniser (≥2)

Ports:
- CLK  in  1  clock; all logic on rising edge
- nRST  in  1  reset, synchronous, active-low
- e2m_valid  in  1  execute/memory stage holds a real instruction
- e2m_pc  in  32  PC of that instruction
- illegal_inst  in  1  illegal-instruction exception
- ecall  in  1  environment call
- ebreak  in  1  breakpoint
- irq_in  in  NUM_IRQ  raw asynchronous interrupt lines
- mstatus_mie  in  1  global interrupt enable
- mie  in  32  per-cause interrupt enable; bits [16+NUM_IRQ-1:16] used
- mtvec_base  in  32  trap base, 4-byte aligned
- mtvec_mode  in  2  0 direct, 1 vectored, 2/3 treated as direct
- trap_valid  out  1  one-cycle commit strobe to CSR
- is_interrupt  out  1  1 interrupt, 0 exception
- trap_pc  out  32  value for mepc
- trap_cause  out  32  value for mcause (bit 31 = interrupt)
- trap_target  out  32  redirect PC
- f2d_flush, d2e_flush, e2m_flush, m2w_flush  out  1 each  pipeline-register flushes
- mip_out  out  32  pending bits at [16+NUM_IRQ-1:16], others 0
- busy  out  1  FSM not IDLE

## Operation
- Per line: SYNC_STAGES synchroniser, then rising-edge detect; edge sets pending[i].
- Interrupt candidate: pending & mie[16 +: NUM_IRQ], gated by mstatus_mie; lowest index wins.
- Exception candidate: illegal (cause 2) > ebreak (cause 3) > ecall (cause 11).
- Exceptions beat interrupts. Candidates are considered only when e2m_valid=1 and state IDLE.
- FSM: IDLE → TAKE on any candidate; TAKE → SETTLE unconditionally; SETTLE → IDLE unconditionally.
- On IDLE→TAKE: latch pc, cause, is_interrupt, target.
- In TAKE: trap_valid=1, all four flushes=1, registered values presented, and pending bit of the taken interrupt cleared.
- SETTLE: no outputs asserted; blocks re-arbitration while CSR clears mstatus.MIE.
- Target: exception or direct mode → mtvec_base; vectored interrupt → mtvec_base + 4*(16+i).
- Same-cycle edge and clear on the same pending bit: set wins; the edge is never lost.
- Edges arriving in TAKE/SETTLE accumulate in pending.

## Timing
- Candidate at edge N (IDLE) → TAKE during N+1 → trap_valid/flushes high exactly one cycle → IDLE at N+3.
- irq_in rise → pending visible on mip_out SYNC_STAGES+1 cycles later.
- Reset: all outputs 0, pending 0, synchronisers 0, state IDLE. nRST low in TAKE aborts; no strobe after the reset edge.
- Inputs changing during TAKE/SETTLE do not alter latched outputs.

## Configuration
- TRAP_VECTORED_EN defined: vectored targets as above.
- Undefined: mtvec_mode ignored; every trap_target = mtvec_base.

## Structure
- Shared package: trap_state_t enum (IDLE, TAKE, SETTLE); cause constants CAUSE_ILLEGAL_INST=2, CAUSE_BREAKPOINT=3, CAUSE_ECALL_M=11, CAUSE_IRQ_BASE=16; MTVEC_DIRECT=0, MTVEC_VECTORED=1.
- Sub-module irq_sync_edge (SYNC_STAGES synchroniser plus edge detect), one instance per line via generate.

## Test plan
- illegal_inst with e2m_pc=0x100, base=0x8000 → next cycle trap_valid, cause=2, trap_pc=0x100, target=0x8000, all flushes, is_interrupt=0.
- irq_in[3] rises, mie[19]=1, mstatus_mie=1, vectored, TRAP_VECTORED_EN → cause=0x80000013, target=0x804C, pending[3] cleared after TAKE.
- irq_in[1] and irq_in[5] rise together → line 1 taken first; mip_out bit 21 stays set; line 5 is taken after SETTLE.
- illegal_inst with pending enabled irq 0 → cause=2 first, then cause=0x80000010.
- mstatus_mie=0 with pending[2] → no trap, mip_out=0x00040000; raise mstatus_mie → trap within 2 cycles.
- nRST low during TAKE → next edge all outputs 0, mip_out=0, busy=0.
